// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   localparam int STRB_W = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data replication and load extraction with
// sign/zero extension. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  size_e               i_size,
   input  logic [1:0]          i_off,
   input  logic                i_unsigned,
   input  logic [31:0]         i_wdata,
   input  logic [31:0]         i_rdata,
   output logic [STRB_W-1:0]   o_wstrb,
   output logic [31:0]         o_wdata,
   output logic [31:0]         o_rdata
);

   logic [31:0] w_shifted;

   assign w_shifted = i_rdata >> {i_off, 3'b000};

   // Lane generation; word (and the illegal code when it reaches the bus) is a full-word access.
   always_comb begin
      o_wstrb = 4'hF;
      o_wdata = i_wdata;
      o_rdata = w_shifted;
      case (i_size)
         SZ_BYTE: begin
            o_wstrb = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
         end
         SZ_HALF: begin
            o_wstrb = 4'b0011 << i_off;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         end
         default: begin
            o_wstrb = 4'hF;
            o_wdata = i_wdata;
            o_rdata = w_shifted;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Turns the datapath's single-cycle memory intent into a valid/ready bus access,
// stalling the core until done. Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   input  logic               req_write,
   input  logic [1:0]         req_size,
   input  logic               req_unsigned,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [DATA_W-1:0]  req_wdata,
   output logic               stall,
   output logic [DATA_W-1:0]  rdata,
   output logic               rdata_valid,
   output logic               misaligned,
   output logic               mem_valid,
   input  logic               mem_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [STRB_W-1:0]  mem_wstrb,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic               mem_rvalid,
   input  logic [DATA_W-1:0]  mem_rdata
);

   state_e               r_state;
   size_e                r_size;
   logic                 r_write;
   logic                 r_unsigned;
   logic [1:0]           r_off;
   logic                 r_mem_valid;
   logic                 r_mem_we;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [STRB_W-1:0]    r_mem_wstrb;
   logic [DATA_W-1:0]    r_mem_wdata;
   logic [DATA_W-1:0]    r_rdata;
   logic                 r_rdata_valid;
   logic                 r_misaligned;

   size_e                w_req_size;
   size_e                w_sel_size;
   logic [1:0]           w_req_off;
   logic [1:0]           w_sel_off;
   logic                 w_sel_unsigned;
   logic                 w_misal;
   logic [STRB_W-1:0]    w_wstrb;
   logic [DATA_W-1:0]    w_wdata;
   logic [DATA_W-1:0]    w_rdata_ext;

   assign w_req_size = size_e'(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_req_off = req_addr[1:0];

   // Natural-alignment check on the incoming request.
   always_comb begin
      w_misal = 1'b1;
      case (w_req_size)
         SZ_BYTE: w_misal = 1'b0;
         SZ_HALF: w_misal = req_addr[0];
         SZ_WORD: w_misal = |req_addr[1:0];
         default: w_misal = 1'b1;
      endcase
   end
`else
   assign w_misal = 1'b0;

   // Force the lane offset to natural alignment instead of trapping.
   always_comb begin
      w_req_off = 2'b00;
      case (w_req_size)
         SZ_BYTE: w_req_off = req_addr[1:0];
         SZ_HALF: w_req_off = {req_addr[1], 1'b0};
         default: w_req_off = 2'b00;
      endcase
   end
`endif

   // Lanes come from the live request while idle, from latched state afterwards.
   assign w_sel_size     = (r_state == IDLE) ? w_req_size   : r_size;
   assign w_sel_off      = (r_state == IDLE) ? w_req_off    : r_off;
   assign w_sel_unsigned = (r_state == IDLE) ? req_unsigned : r_unsigned;

   lsu_align u_align (
      .i_size     (w_sel_size),
      .i_off      (w_sel_off),
      .i_unsigned (w_sel_unsigned),
      .i_wdata    (req_wdata),
      .i_rdata    (mem_rdata),
      .o_wstrb    (w_wstrb),
      .o_wdata    (w_wdata),
      .o_rdata    (w_rdata_ext)
   );

   // Access FSM with registered bus and result outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_size        <= SZ_BYTE;
         r_write       <= 1'b0;
         r_unsigned    <= 1'b0;
         r_off         <= 2'b00;
         r_mem_valid   <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wstrb   <= '0;
         r_mem_wdata   <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_misaligned  <= 1'b0;
      end else begin
         r_rdata_valid <= 1'b0;
         r_misaligned  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_size     <= w_req_size;
                  r_write    <= req_write;
                  r_unsigned <= req_unsigned;
                  r_off      <= w_req_off;
                  if (w_misal) begin
                     r_state      <= DONE;
                     r_misaligned <= 1'b1;
                     r_rdata      <= '0;
                  end else begin
                     r_state     <= REQ;
                     r_mem_valid <= 1'b1;
                     r_mem_we    <= req_write;
                     r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     r_mem_wstrb <= req_write ? w_wstrb : 4'h0;
                     r_mem_wdata <= w_wdata;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            REQ: begin
               if (mem_ready) begin
                  r_mem_valid <= 1'b0;
                  if (r_write) begin
                     r_state <= DONE;
                  end else if (mem_rvalid) begin
                     r_state       <= DONE;
                     r_rdata       <= w_rdata_ext;
                     r_rdata_valid <= 1'b1;
                  end else begin
                     r_state <= WAIT;
                  end
               end else begin
                  r_state <= REQ;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  r_state       <= DONE;
                  r_rdata       <= w_rdata_ext;
                  r_rdata_valid <= 1'b1;
               end else begin
                  r_state <= WAIT;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state     <= IDLE;
               r_mem_valid <= 1'b0;
            end
         endcase
      end
   end

   assign stall       = ((r_state == IDLE) && req_valid) || (r_state == REQ) || (r_state == WAIT);
   assign rdata       = r_rdata;
   assign rdata_valid = r_rdata_valid;
   assign misaligned  = r_misaligned;
   assign mem_valid   = r_mem_valid;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wstrb   = r_mem_wstrb;
   assign mem_wdata   = r_mem_wdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle datapath.
- Consumes ALUResult as the address and writeData as the store data; returns readData for the mem2reg writeback mux.
- Converts the datapath's single-cycle memory intent into a valid/ready transaction on a word-wide data-memory bus, with byte/half/word lanes and sign/zero extension.
- Holds `stall` high so the PC register and regWrite freeze until the access completes.

Parameters:
- ADDR_W, 32, address width (matches `WORD).
- DATA_W, 32, data width; fixed at 32 (four byte lanes).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  datapath requests a memory op this instruction (load or store).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  ADDR_W  byte address (ALUResult).
- req_wdata  in  DATA_W  store data (rs2 value).
- stall  out  1  freeze PC / suppress regWrite.
- rdata  out  DATA_W  extended load data (readData).
- rdata_valid  out  1  one-cycle pulse, load complete.
- misaligned  out  1  one-cycle pulse, access rejected.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus accepts request.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  word-aligned address ({req_addr[31:2],2'b00}).
- mem_wstrb  out  4  byte strobes.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  raw read word.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE.
  - All outputs 0: stall, rdata, rdata_valid, misaligned, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata.
  - Reset mid-transaction abandons the transaction; mem_valid is 0 after that edge; a late mem_rvalid is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On req_valid: latch addr, size, write, unsigned and wdata.
  - Alignment check: half needs addr[0]==0; word needs addr[1:0]==0; size 11 is always misaligned.
  - Aligned -> REQ. Misaligned -> DONE with the misaligned flag set; no bus access.
- REQ: mem_valid=1; mem_we, mem_addr, mem_wstrb, mem_wdata driven from latched values and held stable until mem_ready. On mem_valid&&mem_ready:
  - store -> DONE;
  - load with mem_rvalid in the same cycle -> DONE, data captured;
  - load otherwise -> WAIT.
- WAIT: mem_valid=0. On mem_rvalid, capture mem_rdata -> DONE.
- DONE:
  - stall=0.
  - rdata_valid=1 for a successful load.
  - misaligned=1 if the flag is set; rdata=0 in that case.
  - Always -> IDLE next cycle. req_valid is ignored in DONE, since it still belongs to the finishing instruction.
- stall is combinational: (state==IDLE && req_valid) || state==REQ || state==WAIT.
- Minimum latency, bus ready and rvalid one cycle later:
  - load = 4 cycles (IDLE, REQ, WAIT, DONE);
  - store = 3 cycles.
- Store lanes, with o = addr[1:0]:
  - byte: wstrb = 1<<o, wdata = {4{b}};
  - half: wstrb = 4'b0011<<o, wdata = {2{h}};
  - word: wstrb = 4'hF, wdata = req_wdata.
- Load: shifted = mem_rdata >> (o*8); byte/half sign-extended from bit 7/15 unless req_unsigned; word is passed through.
- rdata holds its last value outside DONE. It is updated only on capture, or cleared on misaligned.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses are rejected as above, with a misaligned pulse.
- Undefined: no alignment check. Address low bits are forced to the natural alignment (half: addr[0]=0, word: addr[1:0]=0); the access proceeds normally; the misaligned port is tied 0.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL);
  - state enum (IDLE, REQ, WAIT, DONE);
  - constant STRB_W=4.
- One sub-module lsu_align: combinational store-lane generation (wstrb/wdata) and load extraction/extension, instantiated once in load_store_unit.

Test Plan:
- Store word 0xDEADBEEF @0x100, mem_ready=1: mem_valid in cycle 1 with addr 0x100, wstrb F, we=1; stall high 2 cycles, low in DONE.
- LB @0x103, mem_rdata=0x80FF_FF00, rvalid one cycle after ready -> rdata=0xFFFFFF80, rdata_valid pulse exactly once.
- LHU @0x102, mem_rdata=0x8001_0000 -> rdata=0x00008001. SB 0xA5 @0x101 -> wstrb 0010, wdata 0xA5A5A5A5.
- mem_ready low for 5 cycles: mem_valid and mem_addr stable; stall high throughout; no duplicate bus request after the handshake.
- LW @0x102 with LSU_MISALIGN_TRAP_EN: no mem_valid, misaligned pulse in cycle 1, rdata=0. Without the macro: access issued at 0x100.
- reset=0 while in WAIT: mem_valid and stall 0 next cycle, state IDLE; subsequent stray mem_rvalid gives no rdata_valid.
